// File: rtl/kbd_mouse_pkg.sv
// Purpose: shared event-type encodings, payload record and default queue depth for kbd_mouse_rx.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kbd_mouse_pkg;

    localparam logic [1:0] KM_MOUSE_X = 2'd0;
    localparam logic [1:0] KM_MOUSE_Y = 2'd1;
    localparam logic [1:0] KM_KBD     = 2'd2;
    localparam logic [1:0] KM_OSD     = 2'd3;

    localparam int KBD_DEPTH_DEF = 8;

    // One sampled input event: type plus payload.
    typedef struct packed {
        logic [1:0] typ;
        logic [7:0] dat;
    } km_evt_t;

endpackage

// File: rtl/kbd_fifo.sv
// Purpose: synchronous first-word-fall-through FIFO for keyboard codes, with full/empty/count.
// Latency: a write is visible at rd_dat one clock later; a read pops on the edge where rd_vld && rd_rdy.
// Backpressure: a write while full is refused unless a read pops on the same edge.
// Ports: wr_vld/wr_dat write side, rd_vld/rd_rdy/rd_dat read side, full/empty/count status.
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             rd_acc, wr_acc;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == (AW+1)'(DEPTH));
    assign count  = cnt_q;
    assign rd_vld = !empty;
    // Present zero while empty so the head output is clean after reset.
    assign rd_dat = empty ? '0 : mem_q[rd_ptr_q];

    assign rd_acc = rd_rdy && !empty;
    // When full, the slot being written is the head being popped on this edge.
    assign wr_acc = wr_vld && (!full || rd_acc);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/kbd_mouse_rx.sv
// Purpose: decode toggle-signalled host events into mouse counters, a keyboard code queue and OSD strobes.
// Latency: 1 clock from the edge that samples a level change to the updated outputs.
// Backpressure: keyboard codes pop on kbd_valid && kbd_ready; a push into a full queue is dropped and sets kbd_ovf.
// Ports: clk_sys/reset; kbd_mouse_level/type/data event input; mouse_xcnt/ycnt; kbd_code/valid/ready/ovf/ovf_clr; osd_code/stb.
// Build option: define KBD_FIFO_EN for a KBD_DEPTH-entry queue; otherwise a single holding register is used.
module kbd_mouse_rx
    import kbd_mouse_pkg::*;
#(
    parameter int KBD_DEPTH = KBD_DEPTH_DEF
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       kbd_mouse_level,
    input  logic [1:0] kbd_mouse_type,
    input  logic [7:0] kbd_mouse_data,
    output logic [7:0] mouse_xcnt,
    output logic [7:0] mouse_ycnt,
    output logic [7:0] kbd_code,
    output logic       kbd_valid,
    input  logic       kbd_ready,
    output logic       kbd_ovf,
    input  logic       kbd_ovf_clr,
    output logic [7:0] osd_code,
    output logic       osd_stb
);
    logic       lvl_q, lvl_d;
    logic [7:0] xcnt_q, xcnt_d;
    logic [7:0] ycnt_q, ycnt_d;
    logic [7:0] osd_code_q, osd_code_d;
    logic       osd_stb_q, osd_stb_d;
    logic       ovf_q, ovf_d;

    km_evt_t    evt_in;
    logic       evt;
    logic       kbd_push, kbd_pop, kbd_full, kbd_drop;

    assign evt_in   = '{typ: kbd_mouse_type, dat: kbd_mouse_data};
    assign evt      = (kbd_mouse_level != lvl_q);
    assign kbd_push = evt && (evt_in.typ == KM_KBD);
    assign kbd_pop  = kbd_valid && kbd_ready;
    assign kbd_drop = kbd_push && kbd_full && !kbd_pop;

    always_comb begin
        lvl_d      = kbd_mouse_level;
        xcnt_d     = xcnt_q;
        ycnt_d     = ycnt_q;
        osd_code_d = osd_code_q;
        osd_stb_d  = 1'b0;
        // An 8-bit add of the raw byte is the sign-extended add taken modulo 256.
        if (evt && evt_in.typ == KM_MOUSE_X) xcnt_d = xcnt_q + evt_in.dat;
        if (evt && evt_in.typ == KM_MOUSE_Y) ycnt_d = ycnt_q + evt_in.dat;
        if (evt && evt_in.typ == KM_OSD) begin
            osd_code_d = evt_in.dat;
            osd_stb_d  = 1'b1;
        end
        // Set has priority over clear so a drop on the clearing edge is not lost.
        ovf_d = (ovf_q && !kbd_ovf_clr) || kbd_drop;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // Track the live level so leaving reset never looks like a toggle.
            lvl_q      <= kbd_mouse_level;
            xcnt_q     <= '0;
            ycnt_q     <= '0;
            osd_code_q <= '0;
            osd_stb_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            lvl_q      <= lvl_d;
            xcnt_q     <= xcnt_d;
            ycnt_q     <= ycnt_d;
            osd_code_q <= osd_code_d;
            osd_stb_q  <= osd_stb_d;
            ovf_q      <= ovf_d;
        end
    end

    assign mouse_xcnt = xcnt_q;
    assign mouse_ycnt = ycnt_q;
    assign osd_code   = osd_code_q;
    assign osd_stb    = osd_stb_q;
    assign kbd_ovf    = ovf_q;

`ifdef KBD_FIFO_EN
    logic                       unused_fifo_empty;
    logic [$clog2(KBD_DEPTH):0] unused_fifo_cnt;

    kbd_fifo #(
        .DEPTH (KBD_DEPTH),
        .WIDTH (8)
    ) u_kbd_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .wr_vld  (kbd_push),
        .wr_dat  (evt_in.dat),
        .rd_vld  (kbd_valid),
        .rd_rdy  (kbd_ready),
        .rd_dat  (kbd_code),
        .full    (kbd_full),
        .empty   (unused_fifo_empty),
        .count   (unused_fifo_cnt)
    );
`else
    // Depth-1 queue: the holding register is full whenever it is valid.
    logic       hold_vld_q, hold_vld_d;
    logic [7:0] hold_dat_q, hold_dat_d;
    logic       hold_acc;
    logic       unused_kbd_depth;

    assign unused_kbd_depth = (KBD_DEPTH != 0);
    assign kbd_full  = hold_vld_q;
    assign hold_acc  = kbd_push && (!hold_vld_q || kbd_pop);

    always_comb begin
        hold_vld_d = hold_vld_q;
        hold_dat_d = hold_dat_q;
        if (hold_acc) begin
            hold_vld_d = 1'b1;
            hold_dat_d = evt_in.dat;
        end else if (kbd_pop) begin
            hold_vld_d = 1'b0;
            hold_dat_d = '0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hold_vld_q <= 1'b0;
            hold_dat_q <= '0;
        end else begin
            hold_vld_q <= hold_vld_d;
            hold_dat_q <= hold_dat_d;
        end
    end

    assign kbd_valid = hold_vld_q;
    assign kbd_code  = hold_dat_q;
`endif
endmodule
